// File: rtl/snake_engine.sv
// Snake core: ring-buffer body + occupancy bitmap. Moves land on the STEP edge (tick + 1). qry_cell answers one cycle after the query.
// tick is dropped, not queued, while busy (STEP/PLACE), IDLE or OVER. Define WRAP_EN to make grid edges wrap instead of kill.
module snake_engine #(
   parameter int  GRID_W   = 64,
   parameter int  GRID_H   = 48,
   parameter int  MAX_LEN  = 32,
   parameter int  SCORE_W  = 8,
   parameter int  START_X  = 30,
   parameter int  START_Y  = 25,
   parameter int  APPLE0_X = 10,
   parameter int  APPLE0_Y = 10,
   localparam int XW       = $clog2(GRID_W),
   localparam int YW       = $clog2(GRID_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start,
   input  logic [3:0]         dir,
   input  logic [XW-1:0]      rand_x,
   input  logic [YW-1:0]      rand_y,
   input  logic [XW-1:0]      qry_x,
   input  logic [YW-1:0]      qry_y,
   output logic [1:0]         qry_cell,
   output logic [XW-1:0]      head_x,
   output logic [YW-1:0]      head_y,
   output logic [XW-1:0]      apple_x,
   output logic [YW-1:0]      apple_y,
   output logic               busy,
   output logic               game_over,
   output logic               won,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int NC = GRID_W * GRID_H;
   localparam int CW = $clog2(NC);

   localparam logic [3:0] D_L = 4'b1000;
   localparam logic [3:0] D_R = 4'b0100;
   localparam logic [3:0] D_U = 4'b0010;
   localparam logic [3:0] D_D = 4'b0001;

`ifdef WRAP_EN
   localparam logic EDGE_KILL = 1'b0;
`else
   localparam logic EDGE_KILL = 1'b1;
`endif

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_PLACE, S_OVER} state_t;
   state_t state, state_nxt;

   logic [NC-1:0] occ;
   logic [XW-1:0] seg_x [MAX_LEN];
   logic [YW-1:0] seg_y [MAX_LEN];
   logic [PW-1:0] head_ptr, tail_ptr, head_ptr_nxt;
   logic [LW-1:0] len;
   logic [3:0]    heading;
   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          off_grid, ate, hit, die, full, place_ok, init;
   logic [1:0]    qry_nxt;

   function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return CW'(y) * CW'(GRID_W) + CW'(x);
   endfunction

   function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (int'(x) < GRID_W) && (int'(y) < GRID_H);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (int'(p) == MAX_LEN - 1) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [3:0] reverse_dir(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   // Candidate head; off_grid only matters when edges kill.
   always_comb begin
      nx       = head_x;
      ny       = head_y;
      off_grid = 1'b0;
      case (heading)
         D_L: if (head_x == '0) begin
                 nx       = XW'(GRID_W - 1);
                 off_grid = EDGE_KILL;
              end else begin
                 nx = head_x - 1'b1;
              end
         D_R: if (int'(head_x) == GRID_W - 1) begin
                 nx       = '0;
                 off_grid = EDGE_KILL;
              end else begin
                 nx = head_x + 1'b1;
              end
         D_U: if (head_y == '0) begin
                 ny       = YW'(GRID_H - 1);
                 off_grid = EDGE_KILL;
              end else begin
                 ny = head_y - 1'b1;
              end
         D_D: if (int'(head_y) == GRID_H - 1) begin
                 ny       = '0;
                 off_grid = EDGE_KILL;
              end else begin
                 ny = head_y + 1'b1;
              end
         default: ;
      endcase
   end

   // The tail vacates on the same edge, so it is a legal target unless the snake grows.
   assign ate          = (nx == apple_x) && (ny == apple_y);
   assign hit          = occ[cell_idx(nx, ny)] &&
                         !(!ate && nx == seg_x[tail_ptr] && ny == seg_y[tail_ptr]);
   assign die          = off_grid || hit;
   assign full         = ate && (int'(len) + 1 == MAX_LEN);
   assign place_ok     = in_grid(rand_x, rand_y) && !occ[cell_idx(rand_x, rand_y)];
   assign init         = rst || (start && (state == S_IDLE || state == S_OVER));
   assign head_ptr_nxt = ptr_inc(head_ptr);
   assign busy         = (state == S_STEP) || (state == S_PLACE);
   assign game_over    = (state == S_OVER);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (tick) state_nxt = S_STEP;
         S_STEP:  if (die || full) state_nxt = S_OVER;
                  else if (ate)    state_nxt = S_PLACE;
                  else             state_nxt = S_RUN;
         S_PLACE: if (place_ok) state_nxt = S_RUN;
         S_OVER:  if (start) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         occ                                           <= '0;
         occ[cell_idx(XW'(START_X), YW'(START_Y))]     <= 1'b1;
         seg_x[0]   <= XW'(START_X);
         seg_y[0]   <= YW'(START_Y);
         head_ptr   <= '0;
         tail_ptr   <= '0;
         len        <= LW'(1);
         head_x     <= XW'(START_X);
         head_y     <= YW'(START_Y);
         apple_x    <= XW'(APPLE0_X);
         apple_y    <= YW'(APPLE0_Y);
         heading    <= D_R;
         score      <= '0;
         won        <= 1'b0;
         if (rst) high_score <= '0;
      end else begin
         if (score > high_score) high_score <= score;
         case (state)
            S_RUN: if (tick && $onehot(dir) &&
                       !(len > LW'(1) && dir == reverse_dir(heading)))
                      heading <= dir;
            S_STEP: if (!die) begin
               head_x              <= nx;
               head_y              <= ny;
               head_ptr            <= head_ptr_nxt;
               seg_x[head_ptr_nxt] <= nx;
               seg_y[head_ptr_nxt] <= ny;
               if (ate) begin
                  len <= len + 1'b1;
                  if (score != '1) score <= score + 1'b1;
                  if (full) won <= 1'b1;
               end else begin
                  occ[cell_idx(seg_x[tail_ptr], seg_y[tail_ptr])] <= 1'b0;
                  tail_ptr <= ptr_inc(tail_ptr);
               end
               // Placed after the tail clear so re-entering the tail cell keeps it set.
               occ[cell_idx(nx, ny)] <= 1'b1;
            end
            S_PLACE: if (place_ok) begin
               apple_x <= rand_x;
               apple_y <= rand_y;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      qry_nxt = 2'b00;
      if (in_grid(qry_x, qry_y)) begin
         if (qry_x == head_x && qry_y == head_y)      qry_nxt = 2'b11;
         else if (occ[cell_idx(qry_x, qry_y)])        qry_nxt = 2'b10;
         else if (qry_x == apple_x && qry_y == apple_y) qry_nxt = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) qry_cell <= 2'b00;
      else     qry_cell <= qry_nxt;
   end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: reset, movement, eating/placement, reversal, self and edge collision, queries, scores.
module tb_snake_engine;

   logic       clk = 1'b0;
   logic       rst, tick, start;
   logic [3:0] dir;
   logic [5:0] rand_x, rand_y, qry_x, qry_y;
   logic [1:0] qry_cell;
   logic [5:0] head_x, head_y, apple_x, apple_y;
   logic       busy, game_over, won;
   logic [7:0] score, high_score;
   int         errors = 0;
   int         checks = 0;

   localparam logic [3:0] L = 4'b1000, R = 4'b0100, U = 4'b0010, D = 4'b0001;

   always #5 clk = ~clk;

   snake_engine dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .dir(dir),
      .rand_x(rand_x), .rand_y(rand_y), .qry_x(qry_x), .qry_y(qry_y),
      .qry_cell(qry_cell), .head_x(head_x), .head_y(head_y),
      .apple_x(apple_x), .apple_y(apple_y), .busy(busy),
      .game_over(game_over), .won(won), .score(score), .high_score(high_score)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_move(input logic [3:0] d);
      dir  = d;
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("busy_in_step", busy, 1);
      step();
   endtask

   task automatic place(input logic [5:0] x, input logic [5:0] y);
      rand_x = x;
      rand_y = y;
      step();
      rand_x = 6'd0;
      rand_y = 6'd63;
      chk("place_busy_clear", busy, 0);
      chk("place_apple_x", apple_x, x);
      chk("place_apple_y", apple_y, y);
   endtask

   task automatic query(input string tag, input logic [5:0] x, input logic [5:0] y,
                        input logic [1:0] exp);
      qry_x = x;
      qry_y = y;
      step();
      chk(tag, qry_cell, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tick = 1'b0; start = 1'b0; dir = 4'b0000;
      rand_x = 6'd0; rand_y = 6'd63; qry_x = 6'd30; qry_y = 6'd25;
      step();
      step();
      chk("rst_head_x", head_x, 30);
      chk("rst_head_y", head_y, 25);
      chk("rst_apple_x", apple_x, 10);
      chk("rst_apple_y", apple_y, 10);
      chk("rst_score", score, 0);
      chk("rst_high", high_score, 0);
      chk("rst_over", game_over, 0);
      chk("rst_won", won, 0);
      chk("rst_busy", busy, 0);
      chk("rst_qry", qry_cell, 0);
      rst = 1'b0;

      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) tick_move(R);
      chk("run3_head_x", head_x, 33);
      chk("run3_head_y", head_y, 25);
      chk("run3_score", score, 0);
      chk("run3_over", game_over, 0);
      chk("run3_busy", busy, 0);

      query("qry_head", 6'd33, 6'd25, 2'b11);
      qry_x = 6'd0; qry_y = 6'd0;
      chk("qry_latency", qry_cell, 2'b11);
      step();
      chk("qry_empty", qry_cell, 2'b00);
      query("qry_apple", 6'd10, 6'd10, 2'b01);
      query("qry_offgrid", 6'd10, 6'd50, 2'b00);

      for (int i = 0; i < 15; i++) tick_move(U);
      chk("nav_head_y", head_y, 10);
      for (int i = 0; i < 22; i++) tick_move(L);
      chk("nav_head_x", head_x, 11);
      chk("nav_score", score, 0);

      tick_move(L);
      chk("eat1_score", score, 1);
      chk("eat1_head_x", head_x, 10);
      chk("eat1_busy", busy, 1);
      step();
      chk("place_offgrid_busy", busy, 1);
      rand_x = 6'd11; rand_y = 6'd10;
      step();
      chk("place_occ_busy", busy, 1);
      chk("place_occ_apple", apple_x, 10);
      place(6'd9, 6'd10);
      query("len2_body", 6'd11, 6'd10, 2'b10);

      tick_move(R);
      chk("reverse_head_x", head_x, 9);
      chk("reverse_head_y", head_y, 10);
      chk("eat2_score", score, 2);
      place(6'd8, 6'd10);
      tick_move(4'b0110);
      chk("multihot_head_x", head_x, 8);
      chk("eat3_score", score, 3);
      place(6'd7, 6'd10);
      tick_move(4'b0000);
      chk("nodir_head_x", head_x, 7);
      chk("eat4_score", score, 4);
      place(6'd6, 6'd10);
      tick_move(L);
      chk("eat5_score", score, 5);
      rand_x = 6'd7; rand_y = 6'd10;
      step();
      chk("place_body_busy", busy, 1);
      place(6'd40, 6'd40);
      chk("high_follows", high_score, 5);
      query("len6_body", 6'd7, 6'd10, 2'b10);
      query("len6_tail", 6'd11, 6'd10, 2'b10);
      query("len6_past_tail", 6'd12, 6'd10, 2'b00);
      query("len6_apple", 6'd40, 6'd40, 2'b01);

      tick_move(D);
      tick_move(R);
      chk("loop_alive", game_over, 0);
      tick_move(U);
      chk("self_hit_over", game_over, 1);
      chk("self_hit_head_x", head_x, 7);
      chk("self_hit_head_y", head_y, 11);
      chk("self_hit_won", won, 0);
      chk("self_hit_score", score, 5);

      dir = L; tick = 1'b1;
      step();
      tick = 1'b0;
      chk("over_tick_busy", busy, 0);
      step();
      chk("over_tick_head", head_x, 7);

      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_score", score, 0);
      chk("restart_high", high_score, 5);
      chk("restart_over", game_over, 0);
      chk("restart_head_x", head_x, 30);
      chk("restart_apple_x", apple_x, 10);
      query("restart_old_body", 6'd7, 6'd10, 2'b00);
      query("restart_head", 6'd30, 6'd25, 2'b11);

      tick_move(R);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_in_run_ignored", head_x, 31);
      for (int i = 0; i < 32; i++) tick_move(R);
      chk("edge_head_x", head_x, 63);
      tick_move(R);
`ifdef WRAP_EN
      chk("wrap_head_x", head_x, 0);
      chk("wrap_alive", game_over, 0);
`else
      chk("edge_over", game_over, 1);
      chk("edge_head_x_kept", head_x, 63);
`endif

      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_high", high_score, 0);
      chk("rst2_over", game_over, 0);
      chk("rst2_head_x", head_x, 30);
      dir = R; tick = 1'b1;
      step();
      tick = 1'b0;
      chk("idle_tick_busy", busy, 0);
      step();
      chk("idle_tick_head", head_x, 30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
